alu_instr_sequencer: RTL and testbench
======================================

Name: alu_instr_sequencer

Overview:
- Hardwired control unit that sequences the existing 32-bit bus datapath through instruction fetch and execution of register-register ALU, MUL/DIV, NEG/NOT, NOP and HALT instructions.
- Generates every control strobe the datapath consumes: register select, bus drivers, latch enables, ALUop, Read.
- Replaces the hand-written T0..T5 stimulus FSMs currently used in the bench-level flow.
- Instruction fields: opcode IR[31:27], Ra (dest) IR[26:23], Rb (src1) IR[22:19], Rc (src2) IR[18:15].

Parameters:
- NREGS, 16, number of general registers; width of the Rin/Rout one-hot vectors.
- OPW, 4, ALUop width.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  synchronous, active-high reset.
- run  in  1  start request; sampled only in IDLE.
- IR  in  32  instruction register contents from the datapath.
- mem_ready  in  1  memory read data valid on Mdatain this cycle.
- Rin  out  NREGS  one-hot register load enable.
- Rout  out  NREGS  one-hot register bus drive.
- PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin  out  1 each  datapath strobes.
- Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin  out  1 each  Z/HI/LO strobes.
- Read  out  1  memory read request.
- ALUop  out  OPW  ALU function select.
- ALU_MUL, ALU_DIV  out  1 each  multiply/divide select.
- busy  out  1  high in any state other than IDLE or HALTED.
- halted  out  1  high in HALTED.
- instr_done  out  1  one-cycle pulse in the final execute state of each instruction.
- illegal  out  1  one-cycle pulse in T3 when the opcode is undefined.

Behaviour:
- Clear: clear=1 at a rising edge forces IDLE regardless of current state, including mid-instruction or while waiting on memory.
- Outputs are Moore, decoded from the registered state and IR; in IDLE and HALTED every output is 0.
- ALUop codes: ADD=3, SUB=4, AND=5, OR=6, SHR=7, SHL=8, ROR=9, ROL=10, NEG=11, NOT=12.
- Opcodes: 00011 add, 00100 sub, 00101 and, 00110 or, 00111 shr, 01000 shl, 01001 ror, 01010 rol, 01111 mul, 10000 div, 10001 neg, 10010 not, 11010 nop, 11011 halt.
- States: IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED.
- IDLE: run=1 -> T0; otherwise stay.
- T0: PCout, MARin, IncPC, Zlowin -> T1.
- T1: Zlowout, PCin, Read, MDRin.
  - Stays in T1 while mem_ready=0, with Read/MDRin held.
  - PCin is asserted only in the cycle where mem_ready=1, so PC increments exactly once.
  - mem_ready=1 -> T2.
- T2: MDRout, IRin -> T3. IR is valid from T3 onward.
- T3, binary ALU ops and mul/div: Rout[Rb], Yin -> T4.
- T3, neg/not: Rout[Rb], ALUop, Zlowin -> T5.
- T3, nop or illegal opcode: instr_done (plus illegal if undefined) -> next fetch.
- T3, halt: instr_done -> HALTED.
- T4, ALU ops: Rout[Rc], ALUop, Zlowin -> T5.
- T4, mul/div: Rout[Rc], ALU_MUL or ALU_DIV, Zlowin, Zhighin -> T5.
- T5, ALU/neg/not: Zlowout, Rin[Ra], instr_done -> next fetch.
- T5, mul/div: Zlowout, LOin -> T6.
- T6 (mul/div only): Zhighout, HIin, instr_done -> next fetch.
- Next fetch means T0 (free-running); run is ignored outside IDLE.
- HALTED: exits only via clear.
- Bus exclusivity: at most one bus driver (Rout bit, PCout, MDRout, Zlowout, Zhighout) is active per cycle; at most one Rin bit is active.
- Latency with zero memory wait: ALU op 6 cycles T0-T5; mul/div 7; neg/not 5; nop 4. Each cycle with mem_ready=0 in T1 adds 1.
- Register index 0 is a normal register; no special-casing.

Optional Feature:
- Macro: SINGLE_STEP_EN.
- Defined: after every instr_done the FSM returns to IDLE instead of T0; the next instruction starts only on a new run=1. HALT behaviour is unchanged.
- Undefined: free-running behaviour as specified above.

Test Plan:
- clear=1 for one edge, then run pulse; IR=0x212B0000 (sub R2,R5,R6), mem_ready=1 -> T3 Rout=0x0020, Yin=1; T4 Rout=0x0040, ALUop=4, Zlowin=1; T5 Zlowout=1, Rin=0x0004, instr_done=1.
- IR=0x781A0000 (mul R3,R4) -> T4 Rout=0x0010, ALU_MUL=1, Zlowin=Zhighin=1; T5 Zlowout, LOin; T6 Zhighout, HIin, instr_done. Instruction takes 7 cycles.
- Hold mem_ready=0 for 3 cycles in T1 -> Read=MDRin=1 for 4 cycles; PCin high exactly 1 cycle, coincident with mem_ready=1; then T2.
- IR opcode 11011 (halt) -> halted=1, busy=0, all strobes 0; run pulses ignored; clear returns the FSM to IDLE.
- Assert clear during T4 of an add -> next cycle IDLE, all outputs 0, no Rin asserted. Undefined opcode 11111 -> illegal and instr_done pulse in T3, next state T0.
- With SINGLE_STEP_EN: after add completes, FSM sits in IDLE with busy=0 until the next run; without the macro, T0 follows T5 immediately.

Source files
------------

// File: rtl/alu_instr_sequencer.sv
// rtl/alu_instr_sequencer.sv - hardwired fetch/execute control unit for the 32-bit bus datapath
// Optional SINGLE_STEP_EN: return to IDLE after every completed instruction instead of fetching the next.
module alu_instr_sequencer #(
  parameter int NREGS = 16,
  parameter int OPW   = 4
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             run,
  input  logic [31:0]      IR,
  input  logic             mem_ready,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic             PCin,
  output logic             PCout,
  output logic             IncPC,
  output logic             MARin,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zlowin,
  output logic             Zhighin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             HIin,
  output logic             LOin,
  output logic             Read,
  output logic [OPW-1:0]   ALUop,
  output logic             ALU_MUL,
  output logic             ALU_DIV,
  output logic             busy,
  output logic             halted,
  output logic             instr_done,
  output logic             illegal
);

  typedef enum logic [3:0] {
    IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED
  } state_t;

  localparam logic [4:0] OP_ADD = 5'b00011;
  localparam logic [4:0] OP_SUB = 5'b00100;
  localparam logic [4:0] OP_AND = 5'b00101;
  localparam logic [4:0] OP_OR  = 5'b00110;
  localparam logic [4:0] OP_SHR = 5'b00111;
  localparam logic [4:0] OP_SHL = 5'b01000;
  localparam logic [4:0] OP_ROR = 5'b01001;
  localparam logic [4:0] OP_ROL = 5'b01010;
  localparam logic [4:0] OP_MUL = 5'b01111;
  localparam logic [4:0] OP_DIV = 5'b10000;
  localparam logic [4:0] OP_NEG = 5'b10001;
  localparam logic [4:0] OP_NOT = 5'b10010;
  localparam logic [4:0] OP_NOP = 5'b11010;
  localparam logic [4:0] OP_HLT = 5'b11011;

  localparam logic [OPW-1:0] ALU_ADD = OPW'(3);
  localparam logic [OPW-1:0] ALU_SUB = OPW'(4);
  localparam logic [OPW-1:0] ALU_AND = OPW'(5);
  localparam logic [OPW-1:0] ALU_OR  = OPW'(6);
  localparam logic [OPW-1:0] ALU_SHR = OPW'(7);
  localparam logic [OPW-1:0] ALU_SHL = OPW'(8);
  localparam logic [OPW-1:0] ALU_ROR = OPW'(9);
  localparam logic [OPW-1:0] ALU_ROL = OPW'(10);
  localparam logic [OPW-1:0] ALU_NEG = OPW'(11);
  localparam logic [OPW-1:0] ALU_NOT = OPW'(12);

`ifdef SINGLE_STEP_EN
  localparam state_t NEXT_FETCH = IDLE;
`else
  localparam state_t NEXT_FETCH = T0;
`endif

  state_t         state;
  logic [4:0]     opcode;
  logic [3:0]     ra, rb, rc;
  logic [NREGS-1:0] sel_a, sel_b, sel_c;
  logic           is_alu, is_muldiv, is_mul, is_unary, is_nop, is_halt, is_illegal;
  logic [OPW-1:0] alu_code;
  logic           unused_ir;

  assign opcode    = IR[31:27];
  assign ra        = IR[26:23];
  assign rb        = IR[22:19];
  assign rc        = IR[18:15];
  assign unused_ir = ^IR[14:0];

  assign sel_a = NREGS'(1) << ra;
  assign sel_b = NREGS'(1) << rb;
  assign sel_c = NREGS'(1) << rc;

  // Instruction class and ALU function; only meaningful once IR is loaded (T3 onward).
  always_comb begin
    is_alu    = 1'b0;
    is_muldiv = 1'b0;
    is_mul    = 1'b0;
    is_unary  = 1'b0;
    is_nop    = 1'b0;
    is_halt   = 1'b0;
    alu_code  = '0;
    case (opcode)
      OP_ADD: begin is_alu = 1'b1; alu_code = ALU_ADD; end
      OP_SUB: begin is_alu = 1'b1; alu_code = ALU_SUB; end
      OP_AND: begin is_alu = 1'b1; alu_code = ALU_AND; end
      OP_OR:  begin is_alu = 1'b1; alu_code = ALU_OR;  end
      OP_SHR: begin is_alu = 1'b1; alu_code = ALU_SHR; end
      OP_SHL: begin is_alu = 1'b1; alu_code = ALU_SHL; end
      OP_ROR: begin is_alu = 1'b1; alu_code = ALU_ROR; end
      OP_ROL: begin is_alu = 1'b1; alu_code = ALU_ROL; end
      OP_MUL: begin is_muldiv = 1'b1; is_mul = 1'b1; end
      OP_DIV: is_muldiv = 1'b1;
      OP_NEG: begin is_unary = 1'b1; alu_code = ALU_NEG; end
      OP_NOT: begin is_unary = 1'b1; alu_code = ALU_NOT; end
      OP_NOP: is_nop = 1'b1;
      OP_HLT: is_halt = 1'b1;
      default: ;
    endcase
    is_illegal = !(is_alu || is_muldiv || is_unary || is_nop || is_halt);
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:   if (run) state <= T0;
        T0:     state <= T1;
        T1:     if (mem_ready) state <= T2;
        T2:     state <= T3;
        T3: begin
          if (is_alu || is_muldiv) state <= T4;
          else if (is_unary)       state <= T5;
          else if (is_halt)        state <= HALTED;
          else                     state <= NEXT_FETCH;
        end
        T4:     state <= T5;
        T5:     state <= is_muldiv ? T6 : NEXT_FETCH;
        T6:     state <= NEXT_FETCH;
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode; PCin alone also looks at mem_ready so the PC advances once per fetch.
  always_comb begin
    Rin        = '0;
    Rout       = '0;
    PCin       = 1'b0;
    PCout      = 1'b0;
    IncPC      = 1'b0;
    MARin      = 1'b0;
    MDRin      = 1'b0;
    MDRout     = 1'b0;
    IRin       = 1'b0;
    Yin        = 1'b0;
    Zlowin     = 1'b0;
    Zhighin    = 1'b0;
    Zlowout    = 1'b0;
    Zhighout   = 1'b0;
    HIin       = 1'b0;
    LOin       = 1'b0;
    Read       = 1'b0;
    ALUop      = '0;
    ALU_MUL    = 1'b0;
    ALU_DIV    = 1'b0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    busy       = (state != IDLE) && (state != HALTED);
    halted     = (state == HALTED);
    case (state)
      T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      T1: begin
        Zlowout = 1'b1;
        Read    = 1'b1;
        MDRin   = 1'b1;
        PCin    = mem_ready;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (is_alu || is_muldiv) begin
          Rout = sel_b;
          Yin  = 1'b1;
        end else if (is_unary) begin
          Rout   = sel_b;
          ALUop  = alu_code;
          Zlowin = 1'b1;
        end else begin
          instr_done = 1'b1;
          illegal    = is_illegal;
        end
      end
      T4: begin
        Rout   = sel_c;
        Zlowin = 1'b1;
        if (is_muldiv) begin
          ALU_MUL = is_mul;
          ALU_DIV = !is_mul;
          Zhighin = 1'b1;
        end else begin
          ALUop = alu_code;
        end
      end
      T5: begin
        Zlowout = 1'b1;
        if (is_muldiv) begin
          LOin = 1'b1;
        end else begin
          Rin        = sel_a;
          instr_done = 1'b1;
        end
      end
      T6: begin
        Zhighout   = 1'b1;
        HIin       = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_instr_sequencer.sv
// tb/tb_alu_instr_sequencer.sv - self-checking bench for alu_instr_sequencer
module tb_alu_instr_sequencer;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic pcin, pcout, incpc, marin, mdrin, mdrout, irin, yin;
    logic zlowin, zhighin, zlowout, zhighout, hiin, loin, read;
    logic [3:0] aluop;
    logic mul, div, busy, halted, done, illegal;
  } ctl_t;

  logic        clock = 1'b0;
  logic        clear, run, mem_ready;
  logic [31:0] IR;
  logic [15:0] Rin, Rout;
  logic PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin;
  logic Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Read;
  logic [3:0] ALUop;
  logic ALU_MUL, ALU_DIV, busy, halted, instr_done, illegal;
  ctl_t obs;

  int checks = 0;
  int errors = 0;
  bit at_idle;
  ctl_t exp_q[$];
  bit   mr_q[$];

  alu_instr_sequencer #(.NREGS(16), .OPW(4)) dut (
    .clock(clock), .clear(clear), .run(run), .IR(IR), .mem_ready(mem_ready),
    .Rin(Rin), .Rout(Rout), .PCin(PCin), .PCout(PCout), .IncPC(IncPC),
    .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout), .Zhighout(Zhighout),
    .HIin(HIin), .LOin(LOin), .Read(Read), .ALUop(ALUop),
    .ALU_MUL(ALU_MUL), .ALU_DIV(ALU_DIV), .busy(busy), .halted(halted),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clock = ~clock;

  assign obs = {Rin, Rout, PCin, PCout, IncPC, MARin, MDRin, MDRout, IRin, Yin,
                Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Read, ALUop,
                ALU_MUL, ALU_DIV, busy, halted, instr_done, illegal};

  task automatic check(input ctl_t exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input int got, input int want, input string tag);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, want);
    end
  endtask

  task automatic bus_check(input string tag);
    int drivers;
    drivers = $countones(Rout) + int'(PCout) + int'(MDRout) + int'(Zlowout) + int'(Zhighout);
    checks++;
    assert (drivers <= 1 && $onehot0(Rin)) else begin
      errors++;
      $error("FAIL %s_bus observed drivers=%0d rin=%h expected drivers<=1 rin onehot0", tag, drivers, Rin);
    end
  endtask

  // Cycle count from T0 to instr_done inclusive, zero memory wait.
  function automatic int latency(input int op);
    if (op >= 3 && op <= 10) return 6;
    if (op == 15 || op == 16) return 7;
    if (op == 17 || op == 18) return 5;
    return 4;
  endfunction

  function automatic ctl_t busy_rec();
    ctl_t c = '0;
    c.busy = 1'b1;
    return c;
  endfunction

  task automatic push(input ctl_t c, input bit mr);
    exp_q.push_back(c);
    mr_q.push_back(mr);
  endtask

  // Reference: expected control word per cycle as a list of micro-operations per instruction class.
  task automatic build(input logic [31:0] ir, input int nwait);
    ctl_t c;
    int op, ra, rb, rc;
    op = int'(ir[31:27]); ra = int'(ir[26:23]); rb = int'(ir[22:19]); rc = int'(ir[18:15]);
    exp_q.delete();
    mr_q.delete();
    c = busy_rec(); c.pcout = 1; c.marin = 1; c.incpc = 1; c.zlowin = 1; push(c, 1'($urandom));
    for (int w = 0; w < nwait; w++) begin
      c = busy_rec(); c.zlowout = 1; c.read = 1; c.mdrin = 1; push(c, 1'b0);
    end
    c = busy_rec(); c.zlowout = 1; c.read = 1; c.mdrin = 1; c.pcin = 1; push(c, 1'b1);
    c = busy_rec(); c.mdrout = 1; c.irin = 1; push(c, 1'($urandom));
    if (op >= 3 && op <= 10) begin
      c = busy_rec(); c.rout = 16'(1 << rb); c.yin = 1; push(c, 1'($urandom));
      c = busy_rec(); c.rout = 16'(1 << rc); c.aluop = 4'(op); c.zlowin = 1; push(c, 1'($urandom));
      c = busy_rec(); c.zlowout = 1; c.rin = 16'(1 << ra); c.done = 1; push(c, 1'($urandom));
    end else if (op == 15 || op == 16) begin
      c = busy_rec(); c.rout = 16'(1 << rb); c.yin = 1; push(c, 1'($urandom));
      c = busy_rec(); c.rout = 16'(1 << rc); c.mul = (op == 15); c.div = (op == 16);
      c.zlowin = 1; c.zhighin = 1; push(c, 1'($urandom));
      c = busy_rec(); c.zlowout = 1; c.loin = 1; push(c, 1'($urandom));
      c = busy_rec(); c.zhighout = 1; c.hiin = 1; c.done = 1; push(c, 1'($urandom));
    end else if (op == 17 || op == 18) begin
      c = busy_rec(); c.rout = 16'(1 << rb); c.aluop = (op == 17) ? 4'd11 : 4'd12;
      c.zlowin = 1; push(c, 1'($urandom));
      c = busy_rec(); c.zlowout = 1; c.rin = 16'(1 << ra); c.done = 1; push(c, 1'($urandom));
    end else begin
      c = busy_rec(); c.done = 1; c.illegal = !(op == 26 || op == 27); push(c, 1'($urandom));
    end
  endtask

  task automatic start(input string tag);
    run = 1'b0;
    mem_ready = 1'($urandom);
    #1 check('0, {tag, "_idle"});
    @(negedge clock);
    #1 check('0, {tag, "_idle_hold"});
    run = 1'b1;
    @(negedge clock);
    run = 1'b0;
  endtask

  // Entered at a falling edge with the DUT in T0 (or IDLE when at_idle is set).
  task automatic exec(input logic [31:0] ir, input int nwait, input int abort_at, input string tag);
    int done_at;
    int op;
    ctl_t hc;
    done_at = -1;
    op = int'(ir[31:27]);
    if (at_idle) start(tag);
    build(ir, nwait);
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_ready = mr_q[i];
      run = 1'($urandom);
      IR = (i >= 3 + nwait) ? ir : $urandom;
      #1 check(exp_q[i], tag);
      bus_check(tag);
      if (instr_done && done_at < 0) done_at = i;
      if (i == abort_at) begin
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        run = 1'b0;
        #1 check('0, {tag, "_cleared"});
        at_idle = 1'b1;
        return;
      end
      @(negedge clock);
    end
    check_int(done_at + 1, latency(op) + nwait, {tag, "_latency"});
    if (op == 27) begin
      hc = '0;
      hc.halted = 1'b1;
      for (int k = 0; k < 3; k++) begin
        run = 1'b1;
        mem_ready = 1'($urandom);
        #1 check(hc, {tag, "_halted"});
        @(negedge clock);
      end
      run = 1'b0;
      clear = 1'b1;
      @(negedge clock);
      clear = 1'b0;
      #1 check('0, {tag, "_unhalt"});
      at_idle = 1'b1;
    end else begin
`ifdef SINGLE_STEP_EN
      at_idle = 1'b1;
`else
      at_idle = 1'b0;
`endif
    end
  endtask

  function automatic logic [31:0] mk(input int op);
    logic [31:0] r;
    r = $urandom;
    r[31:27] = 5'(op);
    return r;
  endfunction

  initial begin
    logic [31:0] ir;
    int nwait, abort_at, len;
    clear = 1'b1;
    run = 1'b0;
    mem_ready = 1'b0;
    IR = '0;
    @(negedge clock);
    @(negedge clock);
    clear = 1'b0;
    #1 check('0, "reset");
    at_idle = 1'b1;

    exec(32'h212B0000, 0, -1, "sub_r2_r5_r6");
    exec(32'h781A0000, 0, -1, "mul_r3_r4");
    exec(mk(3), 3, -1, "add_wait3");
    exec(mk(3), 0, 4, "clear_in_t4");
    exec(mk(31), 0, -1, "illegal_31");
    exec(mk(16), 1, -1, "div");
    exec(mk(17), 0, -1, "neg");
    exec(mk(18), 2, -1, "not");
    exec(mk(26), 0, -1, "nop");
    exec(mk(9), 2, 2, "clear_in_mem_wait");
    exec(mk(27), 1, -1, "halt");

    for (int n = 0; n < 60; n++) begin
      ir = mk($urandom_range(0, 31));
      nwait = $urandom_range(0, 3);
      len = 4 + nwait + latency(int'(ir[31:27]));
      abort_at = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len - 5) : -1;
      exec(ir, nwait, abort_at, "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
